decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Parametrised pipelined decode stage for the 16-bit-instruction core.
//  Sits between fetch and execute: holds the register file, decodes opcode
//  into control signals, selects register or immediate operands, and presents
//  them through a registered valid/ready pipeline slot.
//  Adds load-use stall detection, branch flush and a writeback write port.
// PARAMETERS
//  DATA_W   32  register/operand width
//  PC_W     16  program-counter width
//  NUM_REGS 16  register count; r0 reads 0, writes to r0 ignored; <=16
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       async active-low reset
//  in_valid     in   1       fetch presents an instruction
//  in_ready     out  1       stage accepts instruction this cycle
//  in_pc        in   PC_W    PC of instruction
//  in_inst      in   16      [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rq/imm4
//  flush        in   1       branch resolved taken: kill slot and input
//  wb_en        in   1       register-file write enable
//  wb_addr      in   4       write register
//  wb_data      in   DATA_W  write data
//  out_valid    out  1       slot holds a decoded instruction
//  out_ready    in   1       execute consumes slot this cycle
//  out_pc       out  PC_W    PC of slot instruction
//  out_opa      out  DATA_W  operand A (rs value)
//  out_opb      out  DATA_W  operand B (rq value or sign-extended immediate)
//  out_rd       out  4       destination register
//  out_alu_ctrl out  3       0 ADD 1 SUB 2 AND 3 OR 4 PASSB
//  out_ctrl     out  5       {is_load,is_store,is_branch,is_jump,reg_write}
// BEHAVIOUR
//  - Reset: all out_* and regfile = 0; out_valid=0; in_ready=1 after reset.
//  - Opcodes: 0 ADD,1 SUB,2 AND,3 OR (opb=R[rq]); 4 ADDI (opb=sext(imm4));
//    5 LD, 6 ST (ADD, opb=sext(imm4)); 7 BEQ (SUB, opb=R[rq]); 8 J (PASSB,
//    opb=sext(inst[11:0]), no rs/rq read); others NOP: reg_write=0, ALU ADD.
//  - Latency 1: accepted instruction appears on out_* next cycle.
//  - Accept = in_valid & in_ready. in_ready = (!out_valid | out_ready) & !hazard.
//  - Slot load: accept -> slot gets new decode, out_valid=1; else if
//    out_ready -> out_valid=0; else slot holds, all out_* stable.
//  - hazard = out_valid & is_load(slot) & out_rd!=0 & in_valid &
//    (out_rd==rs | out_rd==rq used by opcode). Stall 1 cycle: slot drains,
//    bubble (out_valid=0) next cycle, instruction then accepted.
//  - flush: highest priority; next cycle out_valid=0, input not accepted
//    (in_ready=0 during flush cycle). Regfile write still happens.
//  - Regfile write on clk edge when wb_en & wb_addr!=0 & wb_addr<NUM_REGS.
//    Read addresses >=NUM_REGS return 0.
//  - Simultaneous wb write and same-register read: see CONFIGURATION.
//  - Reset asserted mid-operation clears slot immediately (async).
// CONFIGURATION
//  WB_BYPASS_EN defined: read ports forward wb_data when wb_en & wb_addr
//    matches (non-zero) in same cycle; decoded operand is the new value.
//  Undefined: read returns old register value; hazard additionally asserts
//    when wb_en & wb_addr matches a used source -> one-cycle stall, re-read.
// TESTING
//  1 Reset, wb r1=5,r2=3; ADD r3,r1,r2 -> next cycle out_opa=5,out_opb=3,
//    alu=0,reg_write=1,out_rd=3.
//  2 ADDI r4,r1,-2 (imm4=0xE) -> out_opb=0xFFFF_FFFE; J 0x800 -> opb=0xFFFF_F800.
//  3 LD r5 in slot, next ADD r6,r5,r1 -> in_ready=0 one cycle, bubble, then ADD
//    accepted; back-to-back independent ops: no stall.
//  4 out_ready=0 three cycles -> out_* stable, in_ready=0; release -> resumes.
//  5 flush with valid slot and in_valid -> next cycle out_valid=0, no accept.
//  6 wb r7=9 same cycle as decode reading r7 -> with WB_BYPASS_EN opa=9 no
//    stall; without, 1 stall then opa=9. Write r0=1 -> r0 reads 0.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : decode_stage
// Purpose : Decode stage for the 16-bit-instruction core. It holds the
//           register file, decodes instructions into one registered
//           valid/ready output slot, and handles load-use stalls, branch
//           flush and the writeback port.
// Option  : WB_BYPASS_EN forwards writeback data to the same-cycle operand
//           reads. When it is not defined, a writeback to a source register
//           causes a one-cycle stall instead.
// Rev     : 1.0  initial release
// ============================================================================
module decode_stage #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 16,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [15:0]       in_inst,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_opa,
  output logic [DATA_W-1:0] out_opb,
  output logic [3:0]        out_rd,
  output logic [2:0]        out_alu_ctrl,
  output logic [4:0]        out_ctrl
);

  localparam int         c_AW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [4:0] c_NREG = 5'(NUM_REGS);
  localparam logic [2:0] c_ALU_ADD = 3'd0, c_ALU_SUB = 3'd1, c_ALU_AND = 3'd2,
                         c_ALU_OR  = 3'd3, c_ALU_PASSB = 3'd4;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic [3:0]        w_op, w_rs, w_rq;
  logic              w_use_rs, w_use_rq, w_use_imm;
  logic [2:0]        w_alu;
  logic [4:0]        w_ctrl;
  logic [DATA_W-1:0] w_imm, w_opa, w_opb;
  logic              w_load_use, w_wb_stall, w_hazard, w_accept, w_wb_hit;

  function automatic logic [DATA_W-1:0] f_read(input logic [3:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a != 4'd0 && {1'b0, a} < c_NREG) begin
      v = r_regs[a[c_AW-1:0]];
`ifdef WB_BYPASS_EN
      if (wb_en && wb_addr == a) v = wb_data;
`endif
    end
    return v;
  endfunction

  assign w_op = in_inst[15:12];
  assign w_rs = in_inst[7:4];
  assign w_rq = in_inst[3:0];

  always_comb begin
    w_use_rs  = 1'b0;
    w_use_rq  = 1'b0;
    w_use_imm = 1'b0;
    w_alu     = c_ALU_ADD;
    w_ctrl    = 5'b00000;
    w_imm     = {{(DATA_W-4){in_inst[3]}}, in_inst[3:0]};
    case (w_op)
      4'd0: begin w_use_rs = 1'b1; w_use_rq = 1'b1; w_ctrl = 5'b00001; end
      4'd1: begin w_use_rs = 1'b1; w_use_rq = 1'b1; w_alu = c_ALU_SUB; w_ctrl = 5'b00001; end
      4'd2: begin w_use_rs = 1'b1; w_use_rq = 1'b1; w_alu = c_ALU_AND; w_ctrl = 5'b00001; end
      4'd3: begin w_use_rs = 1'b1; w_use_rq = 1'b1; w_alu = c_ALU_OR;  w_ctrl = 5'b00001; end
      4'd4: begin w_use_rs = 1'b1; w_use_imm = 1'b1; w_ctrl = 5'b00001; end
      4'd5: begin w_use_rs = 1'b1; w_use_imm = 1'b1; w_ctrl = 5'b10001; end
      4'd6: begin w_use_rs = 1'b1; w_use_imm = 1'b1; w_ctrl = 5'b01000; end
      4'd7: begin w_use_rs = 1'b1; w_use_rq = 1'b1; w_alu = c_ALU_SUB; w_ctrl = 5'b00100; end
      4'd8: begin
        w_use_imm = 1'b1;
        w_alu     = c_ALU_PASSB;
        w_ctrl    = 5'b00010;
        w_imm     = {{(DATA_W-12){in_inst[11]}}, in_inst[11:0]};
      end
      default: ;
    endcase
  end

  // Operands of sources the opcode does not use are forced to zero.
  assign w_opa = w_use_rs ? f_read(w_rs) : '0;
  assign w_opb = w_use_imm ? w_imm : (w_use_rq ? f_read(w_rq) : '0);

  assign w_load_use = out_valid && out_ctrl[4] && out_rd != 4'd0 && in_valid &&
                      ((w_use_rs && out_rd == w_rs) || (w_use_rq && out_rd == w_rq));
`ifdef WB_BYPASS_EN
  assign w_wb_stall = 1'b0;
`else
  assign w_wb_stall = in_valid && wb_en && wb_addr != 4'd0 &&
                      ((w_use_rs && wb_addr == w_rs) || (w_use_rq && wb_addr == w_rq));
`endif
  assign w_hazard = w_load_use || w_wb_stall;
  assign in_ready = (!out_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_wb_hit = wb_en && wb_addr != 4'd0 && {1'b0, wb_addr} < c_NREG;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_hit) begin
      r_regs[wb_addr[c_AW-1:0]] <= wb_data;
    end
  end

  // Flush outranks accept; a held slot keeps every field stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_opa      <= '0;
      out_opb      <= '0;
      out_rd       <= 4'd0;
      out_alu_ctrl <= 3'd0;
      out_ctrl     <= 5'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_opa      <= w_opa;
      out_opb      <= w_opb;
      out_rd       <= in_inst[11:8];
      out_alu_ctrl <= w_alu;
      out_ctrl     <= w_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_stage
// Purpose : Self-checking bench for decode_stage, built from a vector table,
//           directed sequences and randomized traffic checked against a model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [15:0] in_pc, in_inst, out_pc;
  logic [3:0]  wb_addr, out_rd;
  logic [31:0] wb_data, out_opa, out_opb;
  logic [2:0]  out_alu_ctrl;
  logic [4:0]  out_ctrl;

  decode_stage #(.DATA_W(32), .PC_W(16), .NUM_REGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_opa(out_opa),
    .out_opb(out_opb), .out_rd(out_rd), .out_alu_ctrl(out_alu_ctrl),
    .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic s_rdy;

  typedef struct {
    logic        v;
    logic [15:0] pc;
    logic [31:0] a, b;
    logic [3:0]  rd;
    logic [2:0]  alu;
    logic [4:0]  ctrl;
  } slot_t;

  typedef struct {
    logic [15:0] inst;
    logic [31:0] opa, opb;
    logic [2:0]  alu;
    logic [4:0]  ctrl;
  } vec_t;

  logic [31:0] m_regs [16];
  slot_t       m_slot;
  int          alu_tab  [9] = '{0, 1, 2, 3, 0, 0, 0, 1, 4};
  logic [4:0]  ctrl_tab [9] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001,
                                5'b10001, 5'b01000, 5'b00100, 5'b00010};
  vec_t        vt [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 4'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic bit m_uses(input logic [15:0] inst, input logic [3:0] r);
    int op;
    op = int'(inst[15:12]);
    if (op <= 7 && inst[7:4] == r) return 1'b1;
    if ((op <= 3 || op == 7) && inst[3:0] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic slot_t m_decode(input logic [15:0] inst, input logic [15:0] pc);
    slot_t s;
    int op, imm;
    op     = int'(inst[15:12]);
    s.v    = 1'b1;
    s.pc   = pc;
    s.rd   = inst[11:8];
    s.alu  = (op <= 8) ? 3'(alu_tab[op]) : 3'd0;
    s.ctrl = (op <= 8) ? ctrl_tab[op] : 5'd0;
    s.a    = (op <= 7) ? m_read(inst[7:4]) : 32'd0;
    if (op == 8) begin
      imm = int'(inst[11:0]) - (inst[11] ? 4096 : 0);
      s.b = 32'(imm);
    end else if (op >= 4 && op <= 6) begin
      imm = int'(inst[3:0]) - (inst[3] ? 16 : 0);
      s.b = 32'(imm);
    end else if (op <= 3 || op == 7) begin
      s.b = m_read(inst[3:0]);
    end else begin
      s.b = 32'd0;
    end
    return s;
  endfunction

  function automatic logic m_ready();
    bit stall;
    stall = 1'b0;
    if (in_valid) begin
      if (m_slot.v && m_slot.ctrl[4] && m_slot.rd != 0 && m_uses(in_inst, m_slot.rd))
        stall = 1'b1;
`ifndef WB_BYPASS_EN
      if (wb_en && wb_addr != 0 && m_uses(in_inst, wb_addr)) stall = 1'b1;
`endif
    end
    return (!m_slot.v || out_ready) && !stall && !flush;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_slot = '{1'b0, 16'd0, 32'd0, 32'd0, 4'd0, 3'd0, 5'd0};
  endfunction

  // One clock cycle with current inputs; checks in_ready before the edge
  // and the slot after it against the model.
  task automatic tick();
    slot_t nx;
    logic  er;
    #1;
    er    = m_ready();
    s_rdy = in_ready;
    check("in_ready", in_ready, er);
    nx = m_slot;
    if (flush) nx.v = 1'b0;
    else if (in_valid && er) nx = m_decode(in_inst, in_pc);
    else if (out_ready) nx.v = 1'b0;
    @(posedge clk);
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    m_slot = nx;
    #1;
    check("out_valid", out_valid, m_slot.v);
    if (m_slot.v) begin
      check("out_pc",   out_pc, m_slot.pc);
      check("out_opa",  out_opa, m_slot.a);
      check("out_opb",  out_opb, m_slot.b);
      check("out_rd",   out_rd, m_slot.rd);
      check("out_alu",  out_alu_ctrl, m_slot.alu);
      check("out_ctrl", out_ctrl, m_slot.ctrl);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    idle();
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] inst, input logic [15:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_pc = '0; in_inst = '0; wb_addr = '0; wb_data = '0;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready",  in_ready, 1);
    check("rst.out_opa",   out_opa, 0);
    check("rst.out_ctrl",  out_ctrl, 0);
    rst_n = 1'b1;

    // Register setup, including a write to r0 that must be ignored.
    wb_write(4'd1, 32'd5);
    wb_write(4'd2, 32'd3);
    wb_write(4'd0, 32'd1);

    vt[0]  = '{16'h0312, 32'd5,  32'd3,        3'd0, 5'b00001}; // ADD r3,r1,r2
    vt[1]  = '{16'h1321, 32'd3,  32'd5,        3'd1, 5'b00001}; // SUB r3,r2,r1
    vt[2]  = '{16'h2312, 32'd5,  32'd3,        3'd2, 5'b00001}; // AND
    vt[3]  = '{16'h3312, 32'd5,  32'd3,        3'd3, 5'b00001}; // OR
    vt[4]  = '{16'h441E, 32'd5,  32'hFFFFFFFE, 3'd0, 5'b00001}; // ADDI r4,r1,-2
    vt[5]  = '{16'h5521, 32'd3,  32'd1,        3'd0, 5'b10001}; // LD r5,1(r2)
    vt[6]  = '{16'h6518, 32'd5,  32'hFFFFFFF8, 3'd0, 5'b01000}; // ST -8(r1)
    vt[7]  = '{16'h7012, 32'd5,  32'd3,        3'd1, 5'b00100}; // BEQ r1,r2
    vt[8]  = '{16'h8800, 32'd0,  32'hFFFFF800, 3'd4, 5'b00010}; // J 0x800
    vt[9]  = '{16'h9312, 32'd0,  32'd0,        3'd0, 5'b00000}; // NOP
    vt[10] = '{16'h0300, 32'd0,  32'd0,        3'd0, 5'b00001}; // ADD r3,r0,r0
    for (int i = 0; i < 11; i++) begin
      issue(vt[i].inst, 16'(i * 2));
      tick();
      check("vec.opa",  out_opa, vt[i].opa);
      check("vec.opb",  out_opb, vt[i].opb);
      check("vec.alu",  out_alu_ctrl, vt[i].alu);
      check("vec.ctrl", out_ctrl, vt[i].ctrl);
      check("vec.rd",   out_rd, vt[i].inst[11:8]);
      idle();
      tick();
    end

    // Load-use stall, then back-to-back independent instructions.
    issue(16'h5510, 16'h0100); tick();
    issue(16'h0651, 16'h0102); tick();
    check("lu.stall", s_rdy, 0);
    check("lu.bubble", out_valid, 0);
    tick();
    check("lu.accept", s_rdy, 1);
    check("lu.rd", out_rd, 6);
    issue(16'h0712, 16'h0104); tick();
    check("b2b.nostall", s_rdy, 1);
    issue(16'h0812, 16'h0106); tick();
    check("b2b.nostall2", s_rdy, 1);
    check("b2b.pc", out_pc, 16'h0106);

    // Backpressure for three cycles, then release.
    out_ready = 1'b0;
    issue(16'h0912, 16'h0108);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.ready", s_rdy, 0);
      check("bp.pc", out_pc, 16'h0106);
    end
    out_ready = 1'b1;
    tick();
    check("bp.resume", out_pc, 16'h0108);

    // Flush with a valid slot and pending input.
    issue(16'h0A12, 16'h010A);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    check("flush.ready", s_rdy, 0);
    check("flush.valid", out_valid, 0);
    idle(); tick();

    // Writeback to a source register in the decode cycle.
    issue(16'h0870, 16'h0200);
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'd9;
    tick();
    wb_en = 1'b0;
`ifdef WB_BYPASS_EN
    check("wb.nostall", s_rdy, 1);
`else
    check("wb.stall", s_rdy, 0);
    tick();
`endif
    check("wb.opa", out_opa, 32'd9);
    idle(); tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_inst   = {4'($urandom_range(0, 10)), 12'($urandom)};
      in_pc     = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      wb_en     = ($urandom_range(0, 9) < 4);
      wb_addr   = 4'($urandom);
      wb_data   = $urandom;
      tick();
    end

    // Asynchronous reset while a slot is occupied.
    idle();
    issue(16'h0312, 16'h0300);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", out_valid, 0);
    check("arst.opa", out_opa, 0);
    m_reset();
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(16'h0312, 16'h0302);
    tick();
    check("arst.regs", out_opa, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
